// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//
// Contents:
//   DEF_DATA_W, DEF_NREGS, DEF_NRD, DEF_LINK_REG : default parameter values
//   src_e       : source chosen for a registered read
//   bypass_sel  : read-source priority (zero reg > wr1 > wr0 > array)
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NRD      = 2;
  localparam int DEF_LINK_REG = 31;

  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WR0   = 2'd1,
    SRC_WR1   = 2'd2,
    SRC_ZERO  = 2'd3
  } src_e;

  // Register 0 always reads zero. Otherwise a same-cycle write to the read
  // address is forwarded, with wr1 taking precedence over wr0.
  function automatic src_e bypass_sel(input logic addr_zero,
                                      input logic hit_wr0,
                                      input logic hit_wr1);
    src_e sel;
    if (addr_zero)    sel = SRC_ZERO;
    else if (hit_wr1) sel = SRC_WR1;
    else if (hit_wr0) sel = SRC_WR0;
    else              sel = SRC_ARRAY;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard: one pending-producer flag per register.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   set_en / set_addr       : mark a register busy at the edge
//   clr0_en / clr0_addr     : clear from write port 0
//   clr1_en / clr1_addr     : clear from write port 1
//   lookup_addr             : NRD packed lookup addresses
//   busy                    : NRD registered flags, post-edge state of each lookup
//
// A set and a clear of the same bit in one cycle leaves the bit set: the new
// producer is still outstanding. Bit 0 is never busy.
import regfile_pkg::*;

module regfile_sb #(
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic                  clr0_en,
  input  logic [ADDR_W-1:0]     clr0_addr,
  input  logic                  clr1_en,
  input  logic [ADDR_W-1:0]     clr1_addr,
  input  logic [NRD*ADDR_W-1:0] lookup_addr,
  output logic [NRD-1:0]        busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr0_en) busy_d[clr0_addr] = 1'b0;
    if (clr1_en) busy_d[clr1_addr] = 1'b0;
    if (set_en)  busy_d[set_addr]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Lookups see the post-edge state, so this cycle's set/clear is visible.
  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    always_ff @(posedge clk or posedge rst) begin
      if (rst) busy[k] <= 1'b0;
      else     busy[k] <= busy_d[lookup_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports, two write ports
// (wr1 has priority), read-during-write bypass, a registered mirror of one
// link register, and an optional busy scoreboard.
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   rd_addr  [NRD*ADDR_W]       : read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [NRD*DATA_W]       : registered read data, port k at [k*DATA_W +: DATA_W]
//   wr0_en/wr0_addr/wr0_data    : write port 0
//   wr1_en/wr1_addr/wr1_data    : write port 1, wins on same-address conflict
//   link_data                   : registered copy of register LINK_REG
//   sb_set_en / sb_set_addr     : mark a register as having a pending producer
//   rd_busy  [NRD]              : registered pending flag per read address
//
// Build option: define REGFILE_MP_SCOREBOARD_EN to include the scoreboard.
// Without it there is no busy storage and rd_busy is tied to 0.
import regfile_pkg::*;

module regfile_mp #(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = DEF_NRD,
  parameter  int LINK_REG = DEF_LINK_REG,
  localparam int ADDR_W   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  output logic [DATA_W-1:0]     link_data,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr,
  output logic [NRD-1:0]        rd_busy
);

  // Elaboration checks on the parameter set.
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of 2 and >= 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  if (LINK_REG < 0 || LINK_REG >= NREGS) begin : g_bad_link
    $error("regfile_mp: LINK_REG out of range");
  end

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  // Register array. Entry 0 is never written, so it stays zero after reset.
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr0_en && wr0_addr != '0) regs[wr0_addr] <= wr0_data;
      // Issued after wr0 so wr1 lands last on a same-address conflict.
      if (wr1_en && wr1_addr != '0) regs[wr1_addr] <= wr1_data;
    end
  end

  // Read ports: registered, with same-cycle write forwarding.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] next;
    src_e              sel;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      sel = bypass_sel(addr == '0,
                       wr0_en && (wr0_addr == addr),
                       wr1_en && (wr1_addr == addr));
      case (sel)
        SRC_WR1:   next = wr1_data;
        SRC_WR0:   next = wr0_data;
        SRC_ARRAY: next = regs[addr];
        default:   next = '0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data[k*DATA_W +: DATA_W] <= '0;
      else     rd_data[k*DATA_W +: DATA_W] <= next;
    end
  end

  // Link mirror: behaves as a dedicated read port fixed at LINK_REG.
  logic [DATA_W-1:0] link_next;
  src_e              link_sel;

  always_comb begin
    link_sel = bypass_sel(LINK_ADDR == '0,
                          wr0_en && (wr0_addr == LINK_ADDR),
                          wr1_en && (wr1_addr == LINK_ADDR));
    case (link_sel)
      SRC_WR1:   link_next = wr1_data;
      SRC_WR0:   link_next = wr0_data;
      SRC_ARRAY: link_next = regs[LINK_ADDR];
      default:   link_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) link_data <= '0;
    else     link_data <= link_next;
  end

`ifdef REGFILE_MP_SCOREBOARD_EN
  regfile_sb #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en      (sb_set_en),
    .set_addr    (sb_set_addr),
    .clr0_en     (wr0_en),
    .clr0_addr   (wr0_addr),
    .clr1_en     (wr1_en),
    .clr1_addr   (wr1_addr),
    .lookup_addr (rd_addr),
    .busy        (rd_busy)
  );
`else
  // Scoreboard inputs are accepted but have no effect in this build.
  logic unused_sb;
  assign unused_sb = ^{sb_set_en, sb_set_addr};
  assign rd_busy   = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (default parameters): directed vector table, random
// traffic against an architectural model, and asynchronous reset sequences.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

`ifdef REGFILE_MP_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP*AW-1:0]     rd_addr;
  logic [NP*DW-1:0]     rd_data;
  logic                 wr0_en, wr1_en;
  logic [AW-1:0]        wr0_addr, wr1_addr;
  logic [DW-1:0]        wr0_data, wr1_data;
  logic [DW-1:0]        link_data;
  logic                 sb_set_en;
  logic [AW-1:0]        sb_set_addr;
  logic [NP-1:0]        rd_busy;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .link_data   (link_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rd_busy     (rd_busy)
  );

  // ---------------- reference model ----------------
  // Architectural state after each edge; a read returns the post-edge value.
  logic [DW-1:0] mdl_regs [NR];
  bit            mdl_busy [NR];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mdl_regs[i] = '0;
      mdl_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 0; sb_set_addr = '0;
  endtask

  // Apply current inputs across one edge, then check all outputs vs model.
  task automatic cycle();
    logic [AW-1:0] a;
    if (!rst) begin
      if (wr0_en && wr0_addr != 0) mdl_regs[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) mdl_regs[wr1_addr] = wr1_data;
      if (wr0_en) mdl_busy[wr0_addr] = 1'b0;
      if (wr1_en) mdl_busy[wr1_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) mdl_busy[sb_set_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], mdl_regs[a]);
      chk($sformatf("rd_busy[%0d]", k), DW'(rd_busy[k]), DW'(SB_ON && mdl_busy[a]));
    end
    chk("link_data", link_data, mdl_regs[31]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w0e;  logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1e;  logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          sbe;  logic [AW-1:0] sba;
    logic [AW-1:0] r0;   logic [AW-1:0] r1;
    logic [DW-1:0] e_r0; logic [DW-1:0] e_r1;
    logic [1:0]    e_busy;
    logic [DW-1:0] e_link;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic w0e, input int w0a, input logic [DW-1:0] w0d,
                              input logic w1e, input int w1a, input logic [DW-1:0] w1d,
                              input logic sbe, input int sba, input int r0, input int r1,
                              input logic [DW-1:0] e_r0, input logic [DW-1:0] e_r1,
                              input logic [1:0] e_busy, input logic [DW-1:0] e_link);
    vec_t v;
    v.w0e = w0e; v.w0a = AW'(w0a); v.w0d = w0d;
    v.w1e = w1e; v.w1a = AW'(w1a); v.w1d = w1d;
    v.sbe = sbe; v.sba = AW'(sba);
    v.r0 = AW'(r0); v.r1 = AW'(r1);
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_busy = e_busy; v.e_link = e_link;
    return v;
  endfunction

  initial begin
    logic [1:0] eb;
    // reset state
    rst = 1'b1;
    rd_addr = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", rd_data[DW-1:0], '0);
    chk("reset rd_data1", rd_data[2*DW-1:DW], '0);
    chk("reset rd_busy", DW'(rd_busy), '0);
    chk("reset link", link_data, '0);
    rst = 1'b0;

    // read every address on both ports after reset
    for (int a = 0; a < NR; a++) begin
      rd_addr = {AW'(NR - 1 - a), AW'(a)};
      cycle();
    end

    // directed table (register state continues from reset: all zero)
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    tbl[2]  = mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5, 32'h22, 32'hDEADBEEF, 2'b00, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 0);
    tbl[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[5]  = mk(0, 0, 0, 1, 31, 32'h00400010, 0, 0, 31, 0, 32'h00400010, 0, 2'b00, 32'h00400010);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 32'h00400010, 2'b00, 32'h00400010);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 2'b10, 32'h00400010);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 2'b10, 32'h00400010);
    tbl[9]  = mk(1, 9, 32'hAB, 0, 0, 0, 1, 9, 9, 9, 32'hAB, 32'hAB, 2'b11, 32'h00400010);
    tbl[10] = mk(1, 9, 32'hCD, 0, 0, 0, 0, 0, 9, 9, 32'hCD, 32'hCD, 2'b00, 32'h00400010);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 32'hCD, 2'b00, 32'h00400010);

    for (int i = 0; i < 12; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      sb_set_en = tbl[i].sbe; sb_set_addr = tbl[i].sba;
      rd_addr = {tbl[i].r1, tbl[i].r0};
      cycle();
      eb = SB_ON ? tbl[i].e_busy : 2'b00;
      chk($sformatf("tbl%0d rd0", i), rd_data[DW-1:0], tbl[i].e_r0);
      chk($sformatf("tbl%0d rd1", i), rd_data[2*DW-1:DW], tbl[i].e_r1);
      chk($sformatf("tbl%0d busy", i), DW'(rd_busy), DW'(eb));
      chk($sformatf("tbl%0d link", i), link_data, tbl[i].e_link);
    end
    idle();

    // random traffic; small address range half the time to force collisions
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wr0_en = ($urandom_range(0, 2) != 0);
      wr1_en = ($urandom_range(0, 2) == 0);
      sb_set_en = ($urandom_range(0, 2) == 0);
      wr0_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
      wr1_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
      sb_set_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
      wr0_data = $urandom;
      wr1_data = $urandom;
      if ($urandom_range(0, 7) == 0) wr1_addr = 5'd31;
      rd_addr[AW-1:0]    = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
      rd_addr[2*AW-1:AW] = ($urandom_range(0, 1) == 1) ? wr0_addr : wr1_addr;
      cycle();
    end
    idle();

    // fill registers 1..31 and mark a few busy, then reset mid-cycle
    for (int i = 1; i < NR; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = $urandom | 32'h1;
      sb_set_en = (i % 4 == 0); sb_set_addr = AW'(i - 1);
      rd_addr = {AW'(i), AW'(i - 1)};
      cycle();
    end
    idle();
    rd_addr = {AW'(3), AW'(31)};
    cycle();
    chk("pre-reset rd0 nonzero", DW'(rd_data[DW-1:0] != '0), DW'(1));
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async rst rd0", rd_data[DW-1:0], '0);
    chk("async rst rd1", rd_data[2*DW-1:DW], '0);
    chk("async rst busy", DW'(rd_busy), '0);
    chk("async rst link", link_data, '0);

    // writes and sets while held in reset have no effect
    wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'h55;
    wr1_en = 1; wr1_addr = 5'd31; wr1_data = 32'h66;
    sb_set_en = 1; sb_set_addr = 5'd4;
    rd_addr = {AW'(31), AW'(4)};
    cycle();
    cycle();
    rst = 1'b0;
    idle();
    for (int a = 0; a < NR; a++) begin
      rd_addr = {AW'(NR - 1 - a), AW'(a)};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of 2, >=2); ADDR_W = clog2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter LINK_REG, default 31, index mirrored on link_data.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_addr  input  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NRD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W].
REQ-009 wr0_en / wr0_addr / wr0_data  input  1 / ADDR_W / DATA_W  write port 0.
REQ-010 wr1_en / wr1_addr / wr1_data  input  1 / ADDR_W / DATA_W  write port 1 (higher priority).
REQ-011 link_data  output  DATA_W  registered copy of register LINK_REG.
REQ-012 sb_set_en / sb_set_addr  input  1 / ADDR_W  mark a register as having a pending producer.
REQ-013 rd_busy  output  NRD  registered pending flag for each read address.

Function
REQ-014 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded; it SHALL never be busy.
REQ-015 Array writes SHALL occur on the rising clk edge when the corresponding wrN_en=1.
REQ-016 When both ports write the same nonzero address in one cycle, wr1_data SHALL be stored.
REQ-017 rd_data port k SHALL update every cycle with latency 1: value of rd_addr[k] sampled at the edge.
REQ-018 Read-during-write SHALL bypass: if rd_addr[k] matches an enabled write in the same cycle, rd_data[k] SHALL take the new data (wr1 over wr0 over array).
REQ-019 link_data SHALL follow REQ-017/REQ-018 rules for address LINK_REG, every cycle.
REQ-020 Scoreboard: one busy bit per register; sb_set_en sets bit sb_set_addr at the edge.
REQ-021 An enabled write to address A SHALL clear busy bit A at the edge.
REQ-022 Simultaneous set and write-clear of the same address SHALL leave the bit set (new producer wins).
REQ-023 rd_busy[k] SHALL be registered, latency 1, reflecting post-edge busy state of rd_addr[k] (set/clear in that cycle included).
REQ-024 Out-of-range addresses (NREGS not covering ADDR_W space) cannot occur; NREGS power of 2 enforced by elaboration check.

Reset
REQ-025 Asserting rst SHALL immediately clear all registers, all busy bits, rd_data, rd_busy and link_data to 0.
REQ-026 Writes and scoreboard sets presented while rst=1 SHALL be ignored; first effective edge is the first rising clk after deassertion.

Configuration
REQ-027 Macro REGFILE_MP_SCOREBOARD_EN: when defined, REQ-020..REQ-023 implemented as specified.
REQ-028 Without REGFILE_MP_SCOREBOARD_EN, no busy storage SHALL exist, sb_set_* SHALL be ignored and rd_busy SHALL be constant 0; port list unchanged.

Structure
REQ-029 Package regfile_pkg SHALL hold default constants (DATA_W, NREGS, NRD, LINK_REG) and the bypass-priority select function.
REQ-030 Scoreboard SHALL be a sub-module regfile_sb (NREGS busy bits, set/clear ports, NRD lookup ports), instantiated only under REGFILE_MP_SCOREBOARD_EN.

Verification
REQ-031 Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, link_data=0.
REQ-032 wr0 addr 5 data 0xDEADBEEF, same cycle rd_addr[0]=5 -> next cycle rd_data[0]=0xDEADBEEF (bypass); later read still 0xDEADBEEF.
REQ-033 wr0 addr 7 data 0x11, wr1 addr 7 data 0x22 same cycle -> read of 7 returns 0x22; write to 0 data 0xFFFFFFFF -> read 0 returns 0.
REQ-034 wr1 addr 31 data 0x00400010 -> link_data=0x00400010 one cycle later.
REQ-035 sb_set addr 9, next cycle rd_addr[1]=9 -> rd_busy[1]=1; wr0 addr 9 with sb_set addr 9 same cycle -> stays busy; wr0 addr 9 alone -> busy clears; macro undefined -> rd_busy always 0.
REQ-036 Assert rst asynchronously mid-cycle after writes to regs 1..31 -> all outputs 0 before next clk edge; all registers read 0 after release.
